page_to_lane: RTL

PAGE_TO_LANE -- requirements
Module: page_to_lane

---
 rtl/page_to_lane_if.sv | 22 ++
 rtl/page_to_lane.sv | 87 ++++++++
 2 files changed

// File: rtl/page_to_lane_if.sv
// Slice-in / lane-out handshake bundle for page_to_lane; slave = the block, master = its environment.
interface page_to_lane_if;
  logic [24:0] page_in;
  logic        page_valid;
  logic        page_ready;
  logic [63:0] lane_out;
  logic [4:0]  lane_index;
  logic        lane_valid;
  logic        lane_ready;
  logic        lane_last;
  logic        done;

  modport slave (
    input  page_in, page_valid, lane_ready,
    output page_ready, lane_out, lane_index, lane_valid, lane_last, done
  );

  modport master (
    output page_in, page_valid, lane_ready,
    input  page_ready, lane_out, lane_index, lane_valid, lane_last, done
  );
endinterface

// File: rtl/page_to_lane.sv
// Transposes 64 Keccak slices (25 bits each) into 25 lanes of 64 bits; lanes valid the cycle after slice 63.
// Valid/ready on both sides: slices are refused while lanes drain, lanes hold steady while lane_ready is low.
module page_to_lane (
  input  logic           clk,
  input  logic           rst,
  page_to_lane_if.slave  bus
);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  z_q, z_d;
  logic [4:0]  lane_q, lane_d;
  logic        done_q, done_d;
  logic        run_q;
  logic [63:0] buf_q [25];

  logic page_xfer;
  logic lane_xfer;

  // run_q keeps page_ready low while reset is held and until the first clock after release
  assign bus.page_ready = run_q && (state_q == COLLECT);
  assign bus.lane_valid = (state_q == EMIT);
  assign bus.lane_index = lane_q;
  assign bus.lane_out   = buf_q[lane_q];
  assign bus.lane_last  = bus.lane_valid && (lane_q == 5'd24);
  assign bus.done       = done_q;

  assign page_xfer = bus.page_valid && bus.page_ready;
  assign lane_xfer = bus.lane_valid && bus.lane_ready;

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (page_xfer) begin
          z_d = z_q + 6'd1;
          if (z_q == 6'd63) begin
            state_d = EMIT;
            lane_d  = 5'd0;
          end
        end
      end
      EMIT: begin
        if (lane_xfer) begin
          if (lane_q == 5'd24) begin
            lane_d  = 5'd0;
            state_d = COLLECT;
            done_d  = 1'b1;
          end else begin
            lane_d = lane_q + 5'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      z_q     <= 6'd0;
      lane_q  <= 5'd0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end

  // Each frame rewrites every bit, so only the current slice column is touched per transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 25; i++) buf_q[i] <= 64'd0;
    end else if (page_xfer) begin
      for (int i = 0; i < 25; i++) buf_q[i][z_q] <= bus.page_in[i];
    end
  end

endmodule
